// File: rtl/seq_det_1011.sv
// seq_det_1011: Moore overlapping "1011" detector with saturating detection count
module seq_det_1011 #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             x,
    output logic             y,
    output logic             y1,
    output logic [2:0]       st,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] S1 = 3'b001;
    localparam logic [2:0] S2 = 3'b010;
    localparam logic [2:0] S3 = 3'b011;
    localparam logic [2:0] S4 = 3'b100;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [2:0] nxt;
    logic       hit;
    always_ff @(posedge clk) begin
        if (r) begin
            st  <= S0;
            cnt <= '0;
        end else begin
            st  <= nxt;
            cnt <= (hit && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;
        end
    end
    // Illegal codes recover to S0 even while en is low.
    always_comb begin
        nxt = S0;
        case (st)
            S0: nxt = !en ? S0 : (x ? S1 : S0);
            S1: nxt = !en ? S1 : (x ? S1 : S2);
            S2: nxt = !en ? S2 : (x ? S3 : S0);
            S3: nxt = !en ? S3 : (x ? S4 : S2);
            S4: nxt = !en ? S4 : (x ? S1 : S2);
            default: nxt = S0;
        endcase
    end
    always_comb begin
        hit = en && x && st == S3;
        y   = st == S4;
        y1  = ~y;
    end
endmodule

// File: tb/tb_seq_det_1011.sv
// tb_seq_det_1011: directed plus random checks against a bit-history reference model
module tb_seq_det_1011;
    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic       en = 1'b1;
    logic       x = 1'b1;
    logic       y;
    logic       y1;
    logic [2:0] st;
    logic [3:0] cnt;
    int vectors = 0;
    int miscompares = 0;
    // Reference: last four sampled bits since reset and how many are valid.
    logic [3:0] hist = '0;
    int nbits = 0;
    int exp_cnt = 0;
    int pfx[5] = '{0, 1, 2, 5, 11};

    seq_det_1011 #(.CNT_W(4)) dut (
        .clk(clk), .r(r), .en(en), .x(x),
        .y(y), .y1(y1), .st(st), .cnt(cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Progress = longest suffix of the sampled history that is a prefix of "1011".
    function automatic int progress();
        for (int k = 4; k >= 1; k--) begin
            logic [3:0] mask;
            mask = 4'((1 << k) - 1);
            if (nbits >= k && int'(hist & mask) == pfx[k]) return k;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rr, input logic ee, input logic xx);
        int p;
        @(negedge clk);
        r = rr; en = ee; x = xx;
        @(posedge clk);
        if (rr) begin
            hist = '0; nbits = 0; exp_cnt = 0;
        end else if (ee) begin
            hist = {hist[2:0], xx};
            nbits = nbits < 4 ? nbits + 1 : 4;
            if (progress() == 4 && exp_cnt < 15) exp_cnt++;
        end
        #1;
        p = progress();
        check("st", int'(st), p);
        check("y", int'(y), int'(p == 4));
        check("y1", int'(y1), int'(p != 4));
        check("cnt", int'(cnt), exp_cnt);
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i]);
    endtask

    initial begin
        int ypulses;
        step(1, 1, 1);
        step(1, 1, 1);
        check("reset_st", int'(st), 0);
        check("reset_cnt", int'(cnt), 0);
        feed(16'b1011, 4);
        check("basic_y", int'(y), 1);
        check("basic_cnt", int'(cnt), 1);
        step(1, 1, 0);
        feed(16'b1011011, 7);
        check("overlap_cnt", int'(cnt), 2);
        step(1, 1, 0);
        feed(16'b11011, 5);
        check("double1_cnt", int'(cnt), 1);
        step(1, 1, 0);
        feed(16'b101, 3);
        for (int i = 0; i < 3; i++) step(0, 0, 1'(i));
        check("hold_st", int'(st), 3);
        step(0, 1, 1);
        check("gate_y", int'(y), 1);
        step(0, 0, 0);
        check("hold_s4_y", int'(y), 1);
        check("hold_s4_cnt", int'(cnt), 1);
        feed(16'b101, 3);
        step(1, 1, 1);
        check("midreset_st", int'(st), 0);
        check("midreset_cnt", int'(cnt), 0);
        feed(16'b1011, 4);
        check("post_reset_cnt", int'(cnt), 1);
        step(1, 1, 0);
        ypulses = 0;
        for (int g = 0; g < 17; g++) begin
            feed(16'b1011, 4);
            ypulses += int'(y);
        end
        check("sat_cnt", int'(cnt), 15);
        check("sat_pulses", ypulses, 17);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, 1'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
